// File: rtl/if_fetch_block_gen_pkg.sv
// if_fetch_block_gen_pkg: fetch-block types, FSM states and slot-mask helper
package if_fetch_block_gen_pkg;
  localparam int FW_MAX = 16;
  typedef logic [0:0] fbg_state_t;
  localparam fbg_state_t RUN = 1'b0;
  localparam fbg_state_t FAULT_HOLD = 1'b1;
  typedef struct packed {
    logic [63:0]       pc;
    logic [FW_MAX-1:0] mask;
    logic              bp_taken;
    logic [63:0]       bp_target;
    logic              ex_valid;
    logic              ex_fault;
  } fetch_entry_t;
  function automatic logic [FW_MAX-1:0] fetch_slot_mask(input int fw, input int s, input logic taken, input int slot);
    fetch_slot_mask = '0;
    for (int i = 0; i < FW_MAX; i++) fetch_slot_mask[i] = (i < fw) && (i >= s) && (!taken || i <= slot);
  endfunction
endpackage

// File: rtl/if_fetch_block_gen_fetch_queue.sv
// if_fetch_block_gen_fetch_queue: DEPTH-entry FIFO of fetch entries with flush and occupancy
module if_fetch_block_gen_fetch_queue
  import if_fetch_block_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             entry_i,
  output fetch_entry_t             entry_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wr <= r_wr + AW'(1);
      if (pop_i) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_mem[r_wr] <= entry_i;
  end
  assign entry_o = r_mem[r_rd];
  assign count_o = r_count;
endmodule

// File: rtl/if_fetch_block_gen.sv
// if_fetch_block_gen: aligned fetch-block PC generator with icache handshake and fetch queue
module if_fetch_block_gen
  import if_fetch_block_gen_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 4,
  parameter int VADDR_SIZE  = 40,
  localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [63:0]             reset_addr_i,
  input  logic                    stall_i,
  input  logic                    stall_debug_i,
  input  logic                    en_translation_i,
  input  logic                    redirect_valid_i,
  input  logic [63:0]             redirect_pc_i,
  input  logic                    bp_taken_i,
  input  logic [SW-1:0]           bp_slot_i,
  input  logic [63:0]             bp_target_i,
  output logic                    icache_req_valid_o,
  input  logic                    icache_req_ready_i,
  output logic [VADDR_SIZE-1:0]   icache_req_vaddr_o,
  output logic                    icache_flush_o,
  output logic                    fq_valid_o,
  input  logic                    fq_ready_i,
  output logic [63:0]             fq_pc_o,
  output logic [FETCH_WIDTH-1:0]  fq_mask_o,
  output logic                    fq_bp_taken_o,
  output logic [63:0]             fq_bp_target_o,
  output logic                    fq_ex_valid_o,
  output logic                    fq_ex_fault_o,
  output logic [$clog2(DEPTH):0]  fq_count_o
);
  localparam int FB   = 4 * FETCH_WIDTH;
  localparam int OFFW = $clog2(FB);
  localparam int CW   = $clog2(DEPTH) + 1;
  logic [63:0] r_pc;
  fbg_state_t r_state;
  logic [CW-1:0] w_count;
  logic [OFFW-1:0] w_off;
  logic [63:VADDR_SIZE-1] w_upper;
  logic [63:0] w_seq;
  int w_s;
  logic w_mis, w_fault, w_ex, w_eff, w_can_issue, w_accept, w_ex_push, w_push, w_pop, w_unused;
  fetch_entry_t w_entry, w_head;
  assign w_off   = r_pc[OFFW-1:0];
  assign w_s     = int'(w_off) >> 2;
  assign w_upper = r_pc[63:VADDR_SIZE-1];
  assign w_mis   = |r_pc[1:0];
  assign w_fault = en_translation_i && !(&w_upper || ~|w_upper);
  assign w_ex    = w_mis || w_fault;
  // predictions on slots before the entry slot belong to an earlier block
  assign w_eff   = bp_taken_i && (int'(bp_slot_i) >= w_s);
  assign w_seq   = {r_pc[63:OFFW], {OFFW{1'b0}}} + 64'(FB);
  assign w_can_issue = rstn_i && r_state == RUN && !stall_i && !stall_debug_i &&
                       w_count != CW'(DEPTH) && !redirect_valid_i;
  assign w_accept  = icache_req_valid_o && icache_req_ready_i;
  assign w_ex_push = w_can_issue && w_ex;
  assign w_push    = w_accept || w_ex_push;
  assign w_pop     = fq_valid_o && fq_ready_i && !redirect_valid_i;
  always_comb begin
    w_entry = '{pc: r_pc,
                mask: w_ex ? '0 : fetch_slot_mask(FETCH_WIDTH, w_s, w_eff, int'(bp_slot_i)),
                bp_taken: w_eff && !w_ex,
                bp_target: bp_target_i,
                ex_valid: w_ex,
                ex_fault: w_fault && !w_mis};
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pc    <= reset_addr_i;
      r_state <= RUN;
    end else if (redirect_valid_i) begin
      r_pc    <= redirect_pc_i;
      r_state <= RUN;
    end else if (w_accept) begin
      r_pc <= w_eff ? bp_target_i : w_seq;
    end else if (w_ex_push) begin
      r_state <= FAULT_HOLD;
    end
  end
  if_fetch_block_gen_fetch_queue #(.DEPTH(DEPTH)) u_fq (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (redirect_valid_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .entry_i (w_entry),
    .entry_o (w_head),
    .count_o (w_count)
  );
  assign icache_req_valid_o = w_can_issue && !w_ex;
  assign icache_req_vaddr_o = r_pc[VADDR_SIZE-1:0];
  assign icache_flush_o     = rstn_i && redirect_valid_i;
  assign fq_valid_o         = w_count != '0;
  assign fq_pc_o            = w_head.pc;
  assign fq_mask_o          = w_head.mask[FETCH_WIDTH-1:0];
  assign fq_bp_taken_o      = w_head.bp_taken;
  assign fq_bp_target_o     = w_head.bp_target;
  assign fq_ex_valid_o      = w_head.ex_valid;
  assign fq_ex_fault_o      = w_head.ex_fault;
  assign fq_count_o         = w_count;
  assign w_unused           = ^w_head.mask;
endmodule
